// File: rtl/control_sequencer.sv
// Mini SRC control sequencer: a Moore FSM that steps through T0..T7.
// Fetch runs in T0..T2, and the opcode-specific execution starts at T3.
// Every strobe is decoded from the current state plus ir_op.
// Optional feature MEM_WAIT_EN: T1, ld-T6 and st-T7 hold until mem_ready=1.
module control_sequencer #(
   parameter int OPW  = 5,
   parameter int ALUW = 5
) (
   input  logic            clock,
   input  logic            clear,
   input  logic [OPW-1:0]  ir_op,
   input  logic            con_ff,
   input  logic            mem_ready,
   output logic            PCout, MARin, IncPC, PCin, Zin, Zlowout,
   output logic            MDRin, MDRout, Yin, Cout, IRin, CONin,
   output logic            Read, Write,
   output logic            Gra, Grb, Grc, Rin, Rout, BAout,
   output logic [ALUW-1:0] alu_op,
   output logic            run,
   output logic            illegal
);

   localparam logic [3:0] S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
                          S_T3   = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7,
                          S_T7   = 4'd8, S_HALT = 4'd9;

   logic [3:0] state_q, state_d;
   logic       mem_wait;

`ifdef MEM_WAIT_EN
   assign mem_wait = ~mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_wait = 1'b0;
`endif

   // Opcode classes. ir_op is only meaningful from T3 onwards.
   logic is_alu3, is_imm, is_ldi, is_ld, is_st, is_brzr, is_jr, is_nop, is_halt;
   assign is_alu3 = (ir_op >= OPW'(3)) && (ir_op <= OPW'(11));
   assign is_imm  = (ir_op >= OPW'(12)) && (ir_op <= OPW'(14));
   assign is_ldi  = (ir_op == OPW'(1));
   assign is_ld   = (ir_op == OPW'(0));
   assign is_st   = (ir_op == OPW'(2));
   assign is_brzr = (ir_op == OPW'(19));
   assign is_jr   = (ir_op == OPW'(20));
   assign is_nop  = (ir_op == OPW'(26));
   assign is_halt = (ir_op == OPW'(27));

   // Next-state selection: advance one state per cycle, except in the memory wait holds
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   if (!mem_wait) state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3: begin
            if (is_halt)
               state_d = S_HALT;
            else if (is_alu3 || is_imm || is_ldi || is_ld || is_st || is_brzr)
               state_d = S_T4;
            else
               state_d = S_T0;
         end
         S_T4:   state_d = S_T5;
         S_T5:   state_d = (is_ld || is_st || is_brzr) ? S_T6 : S_T0;
         S_T6: begin
            if (is_brzr)
               state_d = S_T0;
            else if (!(is_ld && mem_wait))
               state_d = S_T7;
         end
         S_T7:   if (!(is_st && mem_wait)) state_d = S_T0;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // State register; clear aborts any state, including a held wait state
   always_ff @(posedge clock) begin
      if (!clear) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Moore output decode: strobes last exactly as long as the state does
   always_comb begin
      {PCout, MARin, IncPC, PCin, Zin, Zlowout, MDRin, MDRout, Yin, Cout, IRin, CONin} = '0;
      {Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, illegal} = '0;
      alu_op = '0;
      run    = (state_q != S_IDLE) && (state_q != S_HALT);
      case (state_q)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; alu_op = ALUW'(3); end
         S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: begin
            if (is_alu3 || is_imm) begin
               Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            end else if (is_ldi || is_ld || is_st) begin
               Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end else if (is_brzr) begin
               Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
            end else if (is_jr) begin
               Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
            end else if (!(is_nop || is_halt)) begin
               illegal = 1'b1;
            end
         end
         S_T4: begin
            if (is_alu3) begin
               Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALUW'(ir_op);
            end else if (is_imm) begin
               Cout = 1'b1; Zin = 1'b1; alu_op = ALUW'(ir_op);
            end else if (is_ldi || is_ld || is_st) begin
               Cout = 1'b1; Zin = 1'b1; alu_op = ALUW'(3);
            end else if (is_brzr) begin
               PCout = 1'b1; Yin = 1'b1;
            end
         end
         S_T5: begin
            if (is_alu3 || is_imm || is_ldi) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (is_ld || is_st) begin
               Zlowout = 1'b1; MARin = 1'b1;
            end else if (is_brzr) begin
               Cout = 1'b1; Zin = 1'b1; alu_op = ALUW'(3);
            end
         end
         S_T6: begin
            if (is_ld) begin
               Read = 1'b1; MDRin = 1'b1;
            end else if (is_st) begin
               Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
            end else if (is_brzr) begin
               Zlowout = 1'b1; PCin = con_ff;
            end
         end
         S_T7: begin
            if (is_ld) begin
               MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (is_st) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer. Each instruction's expected per-cycle output
// pattern is built from the opcode rules and queued; a negedge monitor pops and compares.
module tb_control_sequencer;

   typedef struct packed {
      logic       run, illegal;
      logic [4:0] alu_op;
      logic PCout, MARin, IncPC, PCin, Zin, Zlowout, MDRin, MDRout, Yin, Cout, IRin, CONin;
      logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
   } cyc_t;

   logic       clock = 1'b0, clear = 1'b0, con_ff = 1'b0, mem_ready = 1'b0;
   logic [4:0] ir_op = '0;
   cyc_t       got;

   control_sequencer dut (
      .clock(clock), .clear(clear), .ir_op(ir_op), .con_ff(con_ff), .mem_ready(mem_ready),
      .PCout(got.PCout), .MARin(got.MARin), .IncPC(got.IncPC), .PCin(got.PCin),
      .Zin(got.Zin), .Zlowout(got.Zlowout), .MDRin(got.MDRin), .MDRout(got.MDRout),
      .Yin(got.Yin), .Cout(got.Cout), .IRin(got.IRin), .CONin(got.CONin),
      .Read(got.Read), .Write(got.Write), .Gra(got.Gra), .Grb(got.Grb), .Grc(got.Grc),
      .Rin(got.Rin), .Rout(got.Rout), .BAout(got.BAout),
      .alu_op(got.alu_op), .run(got.run), .illegal(got.illegal)
   );

   always #5 clock = ~clock;

   cyc_t exp_q[$];
   int   checks = 0, errors = 0, cyc = 0;
   bit   mon_en = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: every cycle has exactly one queued expectation
   always @(negedge clock) begin
      if (mon_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL underflow cyc %0d: got %h, no expectation queued", cyc, got);
         end else begin
            cyc_t want;
            want = exp_q.pop_front();
            if (got !== want) begin
               errors++;
               $display("FAIL outputs cyc %0d: got %h want %h", cyc, got, want);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic cyc_t run_c();
      cyc_t c;
      c = '0;
      c.run = 1'b1;
      return c;
   endfunction

   // mem_ready value for a cycle; only the wait-capable build cares about it
   function automatic logic mr_at(input bit last);
`ifdef MEM_WAIT_EN
      return last;
`else
      return 1'($urandom);
`endif
   endfunction

   task automatic cycle(input cyc_t e, input logic mr, input logic clr,
                        input logic [4:0] op, input logic con);
      ir_op = op; con_ff = con; mem_ready = mr; clear = clr;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   // Entered while the DUT is in T0. abort_off >= 0 pulls clear low that many cycles after T3.
   task automatic run_instr(input logic [4:0] op, input logic con, input int w1, input int w6,
                            input int w7, input int abort_off, input int halt_len);
      cyc_t seq[$];
      logic mseq[$];
      cyc_t c;
      int   t3, last;
      bit   isalu, isimm;
      isalu = (op >= 5'd3) && (op <= 5'd11);
      isimm = (op >= 5'd12) && (op <= 5'd14);
      c = run_c(); c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.Zin = 1; c.alu_op = 5'd3;
      seq.push_back(c); mseq.push_back(1'($urandom));
      for (int i = 0; i <= w1; i++) begin
         c = run_c(); c.Zlowout = 1; c.PCin = 1; c.Read = 1; c.MDRin = 1;
         seq.push_back(c); mseq.push_back(mr_at(i == w1));
      end
      c = run_c(); c.MDRout = 1; c.IRin = 1;
      seq.push_back(c); mseq.push_back(1'($urandom));
      t3 = seq.size();
      c = run_c();
      if (isalu || isimm) begin
         c.Grb = 1; c.Rout = 1; c.Yin = 1; seq.push_back(c);
         c = run_c(); c.Zin = 1; c.alu_op = op;
         if (isalu) begin c.Grc = 1; c.Rout = 1; end else c.Cout = 1;
         seq.push_back(c);
         c = run_c(); c.Zlowout = 1; c.Gra = 1; c.Rin = 1; seq.push_back(c);
      end else if (op == 5'd1 || op == 5'd0 || op == 5'd2) begin
         c.Grb = 1; c.BAout = 1; c.Yin = 1; seq.push_back(c);
         c = run_c(); c.Cout = 1; c.Zin = 1; c.alu_op = 5'd3; seq.push_back(c);
         c = run_c(); c.Zlowout = 1;
         if (op == 5'd1) begin c.Gra = 1; c.Rin = 1; end else c.MARin = 1;
         seq.push_back(c);
         if (op == 5'd0) begin
            for (int i = 0; i <= w6; i++) begin
               c = run_c(); c.Read = 1; c.MDRin = 1; seq.push_back(c);
            end
            c = run_c(); c.MDRout = 1; c.Gra = 1; c.Rin = 1; seq.push_back(c);
         end else if (op == 5'd2) begin
            c = run_c(); c.Gra = 1; c.Rout = 1; c.MDRin = 1; seq.push_back(c);
            for (int i = 0; i <= w7; i++) begin
               c = run_c(); c.Write = 1; seq.push_back(c);
            end
         end
      end else if (op == 5'd19) begin
         c.Gra = 1; c.Rout = 1; c.CONin = 1; seq.push_back(c);
         c = run_c(); c.PCout = 1; c.Yin = 1; seq.push_back(c);
         c = run_c(); c.Cout = 1; c.Zin = 1; c.alu_op = 5'd3; seq.push_back(c);
         c = run_c(); c.Zlowout = 1; c.PCin = con; seq.push_back(c);
      end else if (op == 5'd20) begin
         c.Gra = 1; c.Rout = 1; c.PCin = 1; seq.push_back(c);
      end else if (op == 5'd26 || op == 5'd27) begin
         seq.push_back(c);
      end else begin
         c.illegal = 1; seq.push_back(c);
      end
      // mem_ready schedule from T3 on: low during ld-T6 / st-T7 waits, high otherwise
      for (int k = t3; k < seq.size(); k++) begin
         bit held;
         held = (op == 5'd0 && k >= t3 + 3 && k < t3 + 3 + w6) ||
                (op == 5'd2 && k >= t3 + 4 && k < t3 + 4 + w7);
         mseq.push_back(held ? 1'b0 : mr_at(1'b1));
      end
      last = (abort_off >= 0) ? t3 + abort_off : seq.size() - 1;
      for (int k = 0; k <= last; k++)
         cycle(seq[k], mseq[k], (k == last && abort_off >= 0) ? 1'b0 : 1'b1,
               (k < t3) ? 5'($urandom) : op, con);
      if (abort_off >= 0) begin
         cycle('0, 1'($urandom), 1'b1, op, con);
      end else if (op == 5'd27) begin
         for (int i = 0; i < halt_len; i++) cycle('0, 1'($urandom), 1'b1, 5'($urandom), con);
         cycle('0, 1'($urandom), 1'b0, 5'($urandom), con);
         cycle('0, 1'($urandom), 1'b1, 5'($urandom), con);
      end
   endtask

   logic [4:0] legal_ops[15] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd9, 5'd11, 5'd12,
                                 5'd13, 5'd14, 5'd19, 5'd20, 5'd26, 5'd27};

   initial begin
      int w1, w6, w7, ab;
      logic [4:0] op;
      @(posedge clock);
      #1;
      mon_en = 1'b1;
      cycle('0, 1'b1, 1'b0, 5'd3, 1'b0);
      cycle('0, 1'b1, 1'b1, 5'd3, 1'b0);
      run_instr(5'd3, 1'b0, 0, 0, 0, -1, 0);
`ifdef MEM_WAIT_EN
      run_instr(5'd0, 1'b0, 0, 3, 0, -1, 0);
      run_instr(5'd2, 1'b1, 2, 0, 2, -1, 0);
`else
      run_instr(5'd0, 1'b0, 0, 0, 0, -1, 0);
      run_instr(5'd2, 1'b1, 0, 0, 0, -1, 0);
`endif
      run_instr(5'd19, 1'b0, 0, 0, 0, -1, 0);
      run_instr(5'd19, 1'b1, 0, 0, 0, -1, 0);
      run_instr(5'd3, 1'b0, 0, 0, 0, 1, 0);
      run_instr(5'd31, 1'b0, 0, 0, 0, -1, 0);
      run_instr(5'd20, 1'b0, 0, 0, 0, -1, 0);
      run_instr(5'd27, 1'b0, 0, 0, 0, -1, 100);
      for (int n = 0; n < 200; n++) begin
         op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 14)];
         w1 = 0; w6 = 0; w7 = 0;
`ifdef MEM_WAIT_EN
         w1 = $urandom_range(0, 3); w6 = $urandom_range(0, 3); w7 = $urandom_range(0, 3);
`endif
         ab = ($urandom_range(0, 9) == 0) ? 0 : -1;
         run_instr(op, 1'($urandom), w1, w6, w7, ab, $urandom_range(1, 4));
      end
      mon_en = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
